// File: rtl/img_xform_ctrl.sv
// ---------------------------------------------------------------------------
// img_xform_ctrl
//
// Controller for a single-port synchronous SRAM used as a square image buffer.
// A STORE job writes IMG_N*IMG_N incoming pixels linearly. A transform job
// reads the stored image back in output raster order, and the address
// generator applies a rotation or mirror on the fly.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle job request, sampled only in IDLE
//   op_mode[2:0] 000 store, 001 rot90 CW, 010 rot180, 011 rot270 CW,
//                100 horizontal mirror, 101 vertical mirror, 11x illegal
//   pix_valid    STORE: a source pixel is present this cycle
//   out_ready    downstream accepts the current output pixel
//   sram_we      SRAM write enable (STORE only)
//   sram_re      SRAM read enable (1-cycle read latency, q holds when idle)
//   sram_addr    SRAM address
//   out_valid    SRAM q carries a valid output pixel
//   jump_out     qualifies out_valid: pixel is the last of its output row
//   busy         high whenever the FSM is not in IDLE
//   output_done  one-cycle pulse at job end
//   err          one-cycle pulse when start sees an illegal op_mode
// ---------------------------------------------------------------------------
module img_xform_ctrl #(
   parameter int IMG_N = 1024,
   parameter int AW    = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    op_mode,
   input  logic          pix_valid,
   input  logic          out_ready,
   output logic          sram_we,
   output logic          sram_re,
   output logic [AW-1:0] sram_addr,
   output logic          out_valid,
   output logic          jump_out,
   output logic          busy,
   output logic          output_done,
   output logic          err
);

   localparam int CW = $clog2(IMG_N);   // bits per coordinate

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      READ,
      DRAIN,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      M_STORE  = 3'd0,
      M_ROT90  = 3'd1,
      M_ROT180 = 3'd2,
      M_ROT270 = 3'd3,
      M_HMIR   = 3'd4,
      M_VMIR   = 3'd5
   } mode_t;

   state_t        state;
   mode_t         mode;
   logic [AW-1:0] wr_idx;
   logic [CW-1:0] row;
   logic [CW-1:0] col;
   logic [CW-1:0] src_r;
   logic [CW-1:0] src_c;
   logic          adv;

   // A read may be issued whenever the output register is empty or is being
   // drained this cycle, so a stalled pixel is never overwritten.
   assign adv = !out_valid || out_ready;

   // Source coordinate for the current output position. IMG_N is a power of
   // two, so N1-x is simply the bitwise complement of x.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      src_r = row;
      src_c = col;
      case (mode)
         M_ROT90:  begin src_r = ~col; src_c = row;  end
         M_ROT180: begin src_r = ~row; src_c = ~col; end
         M_ROT270: begin src_r = col;  src_c = ~row; end
         M_HMIR:   begin src_r = row;  src_c = ~col; end
         M_VMIR:   begin src_r = ~row; src_c = col;  end
         default:  ;
      endcase
   end

   // SRAM strobes follow the current state and this cycle's handshake inputs,
   // so a write lands in the pix_valid cycle and a stalled read is never
   // issued. Both decode to 0 in IDLE, hence also immediately under reset.
   always_comb begin
      sram_we   = (state == STORE) && pix_valid;
      sram_re   = (state == READ) && adv;
      sram_addr = '0;
      if (state == STORE)
         sram_addr = wr_idx;
      else if (state == READ)
         sram_addr = {src_r, src_c};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         mode        <= M_STORE;
         wr_idx      <= '0;
         row         <= '0;
         col         <= '0;
         out_valid   <= 1'b0;
         jump_out    <= 1'b0;
         busy        <= 1'b0;
         output_done <= 1'b0;
         err         <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // read in this block sees the pre-edge value regardless of order.
         output_done <= 1'b0;
         err         <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  wr_idx <= '0;
                  row    <= '0;
                  col    <= '0;
                  if (op_mode == 3'd0) begin
                     mode  <= M_STORE;
                     state <= STORE;
                     busy  <= 1'b1;
                  end else if (op_mode <= 3'd5) begin
                     mode  <= mode_t'(op_mode);
                     state <= READ;
                     busy  <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            STORE: begin
               if (pix_valid) begin
                  wr_idx <= wr_idx + AW'(1);
                  if (wr_idx == '1) begin
                     state       <= DONE;
                     output_done <= 1'b1;
                  end
               end
            end

            READ: begin
               if (adv) begin
                  out_valid <= 1'b1;
                  jump_out  <= (col == '1);
                  col       <= col + CW'(1);
                  if (col == '1) begin
                     row <= row + CW'(1);
                     if (row == '1)
                        state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid   <= 1'b0;
                  jump_out    <= 1'b0;
                  state       <= DONE;
                  output_done <= 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_img_xform_ctrl.sv
// ---------------------------------------------------------------------------
// tb_img_xform_ctrl
//
// Directed bench for img_xform_ctrl with a 4x4 image. Inputs are driven just
// after the falling edge and outputs sampled 1 ns later, well away from the
// rising edge. Transform jobs come from a table of {mode, backpressure,
// expected read-address sequence}; store, illegal-mode and mid-job reset are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_img_xform_ctrl;

   localparam int IMG_N = 4;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    op_mode;
   logic          pix_valid;
   logic          out_ready;
   logic          sram_we;
   logic          sram_re;
   logic [AW-1:0] sram_addr;
   logic          out_valid;
   logic          jump_out;
   logic          busy;
   logic          output_done;
   logic          err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   img_xform_ctrl #(.IMG_N(IMG_N), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op_mode     (op_mode),
      .pix_valid   (pix_valid),
      .out_ready   (out_ready),
      .sram_we     (sram_we),
      .sram_re     (sram_re),
      .sram_addr   (sram_addr),
      .out_valid   (out_valid),
      .jump_out    (jump_out),
      .busy        (busy),
      .output_done (output_done),
      .err         (err)
   );

   // seq[15] is the first read address, seq[0] the last.
   typedef struct {
      logic [2:0]       mode;
      logic             rnd_ready;
      logic [15:0][3:0] seq;
   } job_t;

   job_t jobs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"},    sram_we,     0);
      check({tag, "_re"},    sram_re,     0);
      check({tag, "_addr"},  sram_addr,   0);
      check({tag, "_valid"}, out_valid,   0);
      check({tag, "_jump"},  jump_out,    0);
      check({tag, "_busy"},  busy,        0);
      check({tag, "_done"},  output_done, 0);
      check({tag, "_err"},   err,         0);
   endtask

   // Runs one transform job. abort_at > 0 pulls reset while output number
   // abort_at is being presented and returns without finishing the job.
   task automatic run_read(input logic [2:0] mode, input logic rnd,
                           input logic [15:0][3:0] seq, input int abort_at);
      int   issued   = 0;
      int   accepted = 0;
      int   dones    = 0;
      logic prev_stall = 1'b0;
      logic prev_jump  = 1'b0;

      @(negedge clk);
      start = 1'b1; op_mode = mode; out_ready = 1'b1; pix_valid = 1'b0;
      #1 check("busy_before_start", busy, 0);

      for (int k = 0; k < 300 && dones == 0; k++) begin
         @(negedge clk);
         // Stray starts and mode changes during the job must be ignored.
         start     = ($urandom_range(0, 3) == 0);
         op_mode   = 3'($urandom_range(0, 7));
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;

         if (abort_at > 0 && out_valid && accepted == abort_at - 1) begin
            rst = 1'b0;
            #1 check_all_zero("abort");
            return;
         end

         check("we_in_read",  sram_we, 0);
         check("busy_in_job", busy,    1);
         check("err_in_job",  err,     0);
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_jump",  jump_out,  prev_jump);
         end
         if (out_valid && !out_ready)
            check("re_during_stall", sram_re, 0);
         if (!rnd && k == 0) check("first_valid_lat0", out_valid, 0);
         if (!rnd && k == 1) check("first_valid_lat1", out_valid, 1);

         if (out_valid && out_ready) begin
            check("in_flight", issued - accepted, 1);
            check("jump",      jump_out, (accepted % 4 == 3));
            accepted++;
         end
         if (sram_re) begin
            if (issued < 16)
               check("read_addr", sram_addr, seq[15 - issued]);
            else
               check("extra_issue", issued, 15);
            issued++;
         end
         if (output_done) begin
            dones++;
            check("done_after_all", accepted, 16);
            if (!rnd) check("done_cycle", k, 17);
         end
         prev_stall = out_valid && !out_ready;
         prev_jump  = jump_out;
      end

      if (dones == 0) check("read_timeout", dones, 1);
      check("issued_total", issued, 16);
      @(negedge clk);
      start = 1'b0; out_ready = 1'b1;
      #1;
      check("busy_after_read",  busy,        0);
      check("done_single_cyc",  output_done, 0);
      check("valid_after_read", out_valid,   0);
   endtask

   task automatic run_store();
      int writes = 0;
      int last_w = -1;
      int dones  = 0;

      @(negedge clk);
      start = 1'b1; op_mode = 3'd0; pix_valid = 1'b0; out_ready = 1'b0;
      #1;
      for (int k = 0; k < 200 && dones == 0; k++) begin
         @(negedge clk);
         pix_valid = (k % 3 != 1);
         start     = (k == 5);        // ignored: job already running
         op_mode   = 3'b111;
         #1;
         check("re_in_store",  sram_re, 0);
         check("err_in_store", err,     0);
         if (output_done) begin
            dones++;
            check("store_done_latency", k - last_w, 1);
            check("store_writes",       writes,     16);
         end else begin
            check("we_follows_valid", sram_we, pix_valid);
            if (sram_we) begin
               check("store_addr", sram_addr, writes);
               writes++;
               last_w = k;
            end
         end
      end
      if (dones == 0) check("store_timeout", dones, 1);

      @(negedge clk);
      start = 1'b0; pix_valid = 1'b1;
      #1;
      check("we_after_store",   sram_we, 0);
      check("busy_after_store", busy,    0);
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic run_illegal(input logic [2:0] mode);
      @(negedge clk);
      start = 1'b1; op_mode = mode;
      #1 check("err_before", err, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("err_pulse",     err,     1);
      check("illegal_busy",  busy,    0);
      check("illegal_we",    sram_we, 0);
      check("illegal_re",    sram_re, 0);
      @(negedge clk);
      #1;
      check("err_clear",     err,     0);
      check("illegal_busy2", busy,    0);
      check("illegal_re2",   sram_re, 0);
   endtask

   initial begin
      jobs[0] = '{mode: 3'b001, rnd_ready: 1'b0, seq: 64'hC840_D951_EA62_FB73};
      jobs[1] = '{mode: 3'b001, rnd_ready: 1'b1, seq: 64'hC840_D951_EA62_FB73};
      jobs[2] = '{mode: 3'b010, rnd_ready: 1'b0, seq: 64'hFEDC_BA98_7654_3210};
      jobs[3] = '{mode: 3'b011, rnd_ready: 1'b0, seq: 64'h37BF_26AE_159D_048C};
      jobs[4] = '{mode: 3'b100, rnd_ready: 1'b0, seq: 64'h3210_7654_BA98_FEDC};
      jobs[5] = '{mode: 3'b101, rnd_ready: 1'b0, seq: 64'hCDEF_89AB_4567_0123};
      jobs[6] = '{mode: 3'b100, rnd_ready: 1'b1, seq: 64'h3210_7654_BA98_FEDC};

      rst = 1'b0; start = 1'b0; op_mode = 3'd0; pix_valid = 1'b0; out_ready = 1'b0;
      #2 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_store();
      run_illegal(3'b111);
      run_illegal(3'b110);

      for (int i = 0; i < 7; i++)
         run_read(jobs[i].mode, jobs[i].rnd_ready, jobs[i].seq, -1);

      // Reset while output 7 of a rot270 job is on the bus.
      run_read(3'b011, 1'b0, jobs[3].seq, 7);
      repeat (2) begin
         @(negedge clk);
         start = 1'b1; op_mode = 3'b011;
         #1;
         check("busy_in_reset",  busy,      0);
         check("valid_in_reset", out_valid, 0);
      end
      @(negedge clk);
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         check("idle_after_abort_busy", busy,        0);
         check("idle_after_abort_done", output_done, 0);
         check("idle_after_abort_re",   sram_re,     0);
      end
      run_read(3'b011, 1'b0, jobs[3].seq, -1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
